// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns one MEM-stage load or store into a req/ack
// transaction, stalls the pipeline while it is in flight and formats load data.
module mem_stage_lsu #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        iClk,
   input  logic        iRstN,
   input  logic        iMemReadM,
   input  logic        iMemWriteM,
   input  logic [2:0]  iFunct3M,
   input  logic [31:0] iALUOutM,
   input  logic [31:0] iWriteDataM,
   output logic [31:0] oReadDataM,
   output logic        oStallM,
   output logic        oMisalignM,
   output logic        oBusErrM,
   output logic        oMemReq,
   output logic        oMemWe,
   output logic [31:0] oMemAddr,
   output logic [31:0] oMemWData,
   output logic [3:0]  oMemBe,
   input  logic        iMemAck,
   input  logic [31:0] iMemRData
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       funct3_q;
   logic [1:0]       lane_q;

   logic             access;
   logic             fault;
   logic             start;
   logic [3:0]       be_d;
   logic [31:0]      wdata_d;

   function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                            input logic [1:0]  lane,
                                            input logic [31:0] word);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b100:  return {24'h0, sh[7:0]};
         3'b101:  return {16'h0, sh[15:0]};
         default: return word;
      endcase
   endfunction

   // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
   always_comb begin
      access = iMemReadM | iMemWriteM;
      case (iFunct3M)
         3'b000, 3'b100: fault = 1'b0;
         3'b001, 3'b101: fault = iALUOutM[0];
         3'b010:         fault = |iALUOutM[1:0];
         default:        fault = 1'b1;
      endcase
      start = (state == IDLE) && access && !fault;
   end

   // Stores pick their lanes from the low address bits; loads always fetch the whole word.
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = iWriteDataM;
      if (iMemWriteM) begin
         case (iFunct3M[1:0])
            2'b00: begin
               be_d    = 4'b0001 << iALUOutM[1:0];
               wdata_d = {4{iWriteDataM[7:0]}};
            end
            2'b01: begin
               be_d    = iALUOutM[1] ? 4'b1100 : 4'b0011;
               wdata_d = {2{iWriteDataM[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // Reset gates the combinational flags so nothing upstream is held while in reset.
   assign oStallM    = iRstN & (start | (state == BUSY));
   assign oMisalignM = iRstN & (state == IDLE) & access & fault;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state      <= IDLE;
         cnt        <= '0;
         funct3_q   <= '0;
         lane_q     <= '0;
         oReadDataM <= '0;
         oBusErrM   <= 1'b0;
         oMemReq    <= 1'b0;
         oMemWe     <= 1'b0;
         oMemAddr   <= '0;
         oMemWData  <= '0;
         oMemBe     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  oMemReq   <= 1'b1;
                  oMemWe    <= iMemWriteM;
                  oMemAddr  <= {iALUOutM[31:2], 2'b00};
                  oMemBe    <= be_d;
                  oMemWData <= wdata_d;
                  funct3_q  <= iFunct3M;
                  lane_q    <= iALUOutM[1:0];
                  cnt       <= '0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt + CNT_W'(1);
               // An ack in the last allowed cycle still completes normally.
               if (iMemAck) begin
                  oMemReq <= 1'b0;
                  if (!oMemWe) oReadDataM <= fmt_load(funct3_q, lane_q, iMemRData);
                  state   <= DONE;
               end else if (TIMEOUT_EN && cnt == TIMEOUT_LAST) begin
                  oMemReq    <= 1'b0;
                  oReadDataM <= '0;
                  oBusErrM   <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               oBusErrM <= 1'b0;
               cnt      <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus randomized accesses
// checked against a byte-lane arithmetic model of loads, stores and timeouts.
module tb_mem_stage_lsu;

   localparam int TO = 4;

   logic        iClk = 1'b0;
   logic        iRstN;
   logic        iMemReadM;
   logic        iMemWriteM;
   logic [2:0]  iFunct3M;
   logic [31:0] iALUOutM;
   logic [31:0] iWriteDataM;
   logic [31:0] oReadDataM;
   logic        oStallM;
   logic        oMisalignM;
   logic        oBusErrM;
   logic        oMemReq;
   logic        oMemWe;
   logic [31:0] oMemAddr;
   logic [31:0] oMemWData;
   logic [3:0]  oMemBe;
   logic        iMemAck;
   logic [31:0] iMemRData;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_rd;
   logic [3:0]  last_be;
   logic [31:0] last_wdata;
   logic [31:0] last_addr;
   logic        last_we;

   always #5 iClk = ~iClk;

   mem_stage_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
      .iClk        (iClk),
      .iRstN       (iRstN),
      .iMemReadM   (iMemReadM),
      .iMemWriteM  (iMemWriteM),
      .iFunct3M    (iFunct3M),
      .iALUOutM    (iALUOutM),
      .iWriteDataM (iWriteDataM),
      .oReadDataM  (oReadDataM),
      .oStallM     (oStallM),
      .oMisalignM  (oMisalignM),
      .oBusErrM    (oBusErrM),
      .oMemReq     (oMemReq),
      .oMemWe      (oMemWe),
      .oMemAddr    (oMemAddr),
      .oMemWData   (oMemWData),
      .oMemBe      (oMemBe),
      .iMemAck     (iMemAck),
      .iMemRData   (iMemRData)
   );

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [2:0] f3);
      case (f3 % 4)
         0:       return 1;
         1:       return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit is_fault(input logic [2:0] f3, input logic [31:0] addr);
      case (f3)
         3'd0, 3'd4: return 1'b0;
         3'd1, 3'd5: return (addr % 2) != 0;
         3'd2:       return (addr % 4) != 0;
         default:    return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] word);
      int          n;
      logic [31:0] v;
      logic [31:0] mask;
      n = nbytes(f3);
      if (n == 4) return word;
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = (word >> (8 * (addr % 4))) & mask;
      if (f3 < 4 && v > (mask >> 1)) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [3:0] model_be(input bit wr, input logic [2:0] f3,
                                           input logic [31:0] addr);
      if (!wr || nbytes(f3) == 4) return 4'hF;
      if (nbytes(f3) == 1) return 4'(1 << (addr % 4));
      return (addr % 4 >= 2) ? 4'hC : 4'h3;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (nbytes(f3))
         1:       return 32'(wd[7:0]) * 32'h0101_0101;
         2:       return 32'(wd[15:0]) * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   // One complete access starting in IDLE; ack_cyc is the BUSY cycle (1-based) that
   // carries the ack, anything outside 1..TO means no ack at all.
   task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int ack_cyc, input logic [31:0] rdata);
      bit          fault;
      bit          timed_out;
      logic [31:0] exp_addr;
      fault    = is_fault(f3, addr);
      exp_addr = addr & 32'hFFFF_FFFC;
      @(posedge iClk); #1;
      iMemReadM   = rd;
      iMemWriteM  = wr;
      iFunct3M    = f3;
      iALUOutM    = addr;
      iWriteDataM = wd;
      iMemAck     = 1'($urandom);
      iMemRData   = $urandom;
      @(negedge iClk);
      checks++;
      if ({oMisalignM, oStallM, oMemReq, oBusErrM} !== {fault, ~fault, 2'b00}) begin
         errors++;
         $display("FAIL idle_flags addr=%h f3=%b: misalign,stall,req,buserr=%b expected %b",
                  addr, f3, {oMisalignM, oStallM, oMemReq, oBusErrM}, {fault, ~fault, 2'b00});
      end
      if (fault) begin
         @(posedge iClk); #1;
         iMemReadM = 1'b0; iMemWriteM = 1'b0; iMemAck = 1'b0;
         @(negedge iClk);
         checks++;
         if ({oMemReq, oStallM} !== 2'b00 || oReadDataM !== exp_rd) begin
            errors++;
            $display("FAIL fault_drop addr=%h: req,stall=%b rdata=%h expected 00 rdata=%h",
                     addr, {oMemReq, oStallM}, oReadDataM, exp_rd);
         end
         return;
      end
      for (int c = 1; c <= TO; c++) begin
         @(posedge iClk); #1;
         iMemAck   = (c == ack_cyc);
         iMemRData = (c == ack_cyc) ? rdata : $urandom;
         @(negedge iClk);
         if (c == 1) begin
            last_be = oMemBe; last_wdata = oMemWData; last_addr = oMemAddr; last_we = oMemWe;
         end
         checks++;
         if ({oMemReq, oStallM, oMisalignM, oMemWe} !== {3'b110, wr} || oMemAddr !== exp_addr ||
             oMemBe !== model_be(wr, f3, addr) || (wr && oMemWData !== model_wdata(f3, wd))) begin
            errors++;
            $display("FAIL busy_bus cyc=%0d addr=%h f3=%b: req,stall,mis,we=%b a=%h be=%b wd=%h expected %b a=%h be=%b wd=%h",
                     c, addr, f3, {oMemReq, oStallM, oMisalignM, oMemWe}, oMemAddr, oMemBe, oMemWData,
                     {3'b110, wr}, exp_addr, model_be(wr, f3, addr), model_wdata(f3, wd));
         end
         if (c == ack_cyc) break;
      end
      timed_out = (ack_cyc < 1 || ack_cyc > TO);
      @(posedge iClk); #1;
      iMemAck = 1'b0; iMemReadM = 1'b0; iMemWriteM = 1'b0;
      if (timed_out) exp_rd = '0;
      else if (!wr) exp_rd = model_load(f3, addr, rdata);
      @(negedge iClk);
      checks++;
      if ({oStallM, oMemReq, oBusErrM} !== {2'b00, timed_out}) begin
         errors++;
         $display("FAIL done_flags addr=%h: stall,req,buserr=%b expected %b",
                  addr, {oStallM, oMemReq, oBusErrM}, {2'b00, timed_out});
      end
      checks++;
      if (oReadDataM !== exp_rd) begin
         errors++;
         $display("FAIL done_rdata addr=%h f3=%b: got %h expected %h", addr, f3, oReadDataM, exp_rd);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      iRstN = 1'b0;
      iMemReadM = 1'b1; iMemWriteM = 1'b0; iFunct3M = 3'b010; iALUOutM = 32'h100;
      iWriteDataM = 32'h5555_AAAA; iMemAck = 1'b1; iMemRData = 32'h1234_5678;
      repeat (2) @(negedge iClk);
      checks++;
      if ({oStallM, oMisalignM, oMemReq, oBusErrM, oMemWe} !== 5'b0 || oMemAddr !== 32'h0 ||
          oMemBe !== 4'h0 || oMemWData !== 32'h0 || oReadDataM !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: flags=%b addr=%h be=%b wd=%h rd=%h expected all zero",
                  {oStallM, oMisalignM, oMemReq, oBusErrM, oMemWe}, oMemAddr, oMemBe, oMemWData, oReadDataM);
      end
      iMemReadM = 1'b0; iMemAck = 1'b0;
      iRstN = 1'b1;
      exp_rd = '0;
      @(negedge iClk);
      checks++;
      if ({oStallM, oMemReq, oMisalignM} !== 3'b000) begin
         errors++;
         $display("FAIL reset_release: stall,req,mis=%b expected 000", {oStallM, oMemReq, oMisalignM});
      end
   endtask

   task automatic test_load_word();
      run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEAD_BEEF);
      checks++;
      if (oReadDataM !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL lw_value: got %h expected deadbeef", oReadDataM);
      end
   endtask

   task automatic test_load_byte();
      run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_0000);
      checks++;
      if (oReadDataM !== 32'hFFFF_FF80) begin
         errors++;
         $display("FAIL lb_value: got %h expected ffffff80", oReadDataM);
      end
      run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 3, 32'h80FF_0000);
      checks++;
      if (oReadDataM !== 32'h0000_0080) begin
         errors++;
         $display("FAIL lbu_value: got %h expected 00000080", oReadDataM);
      end
   endtask

   task automatic test_store_half();
      run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 1, 32'hFFFF_FFFF);
      checks++;
      if ({last_we, last_be} !== 5'b11100 || last_wdata !== 32'hABCD_ABCD || last_addr !== 32'h100) begin
         errors++;
         $display("FAIL sh_bus: we=%b be=%b wd=%h addr=%h expected we=1 be=1100 wd=abcdabcd addr=00000100",
                  last_we, last_be, last_wdata, last_addr);
      end
      checks++;
      if (oReadDataM !== 32'h0000_0080) begin
         errors++;
         $display("FAIL sh_keeps_rdata: got %h expected 00000080", oReadDataM);
      end
   endtask

   task automatic test_misalign();
      run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1, 32'h1111_1111);
      run_access(1'b1, 1'b0, 3'b101, 32'h203, 32'h0, 1, 32'h2222_2222);
      run_access(1'b0, 1'b1, 3'b110, 32'h200, 32'h3333_3333, 1, 32'h0);
   endtask

   task automatic test_idle_hold();
      for (int i = 0; i < 3; i++) begin
         @(posedge iClk); #1;
         iMemReadM = 1'b0; iMemWriteM = 1'b0; iMemAck = 1'b1; iMemRData = $urandom;
         iALUOutM = $urandom; iFunct3M = 3'($urandom);
         @(negedge iClk);
         checks++;
         if ({oStallM, oMemReq, oMisalignM, oBusErrM} !== 4'b0000 || oReadDataM !== exp_rd) begin
            errors++;
            $display("FAIL idle_hold cyc=%0d: stall,req,mis,buserr=%b rd=%h expected 0000 rd=%h",
                     i, {oStallM, oMemReq, oMisalignM, oBusErrM}, oReadDataM, exp_rd);
         end
      end
      iMemAck = 1'b0;
   endtask

   task automatic test_timeout();
      run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, TO, 32'h7654_3210);
      run_access(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 0, 32'h0);
      checks++;
      if (oReadDataM !== 32'h0 || oBusErrM !== 1'b1) begin
         errors++;
         $display("FAIL timeout_result: rd=%h buserr=%b expected 00000000 1", oReadDataM, oBusErrM);
      end
      run_access(1'b0, 1'b1, 3'b000, 32'h405, 32'hAB, 0, 32'h0);
   endtask

   task automatic test_reset_mid_busy();
      run_access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1, 32'hCAFE_F00D);
      @(posedge iClk); #1;
      iMemReadM = 1'b1; iMemWriteM = 1'b0; iFunct3M = 3'b010; iALUOutM = 32'h300;
      repeat (2) begin @(posedge iClk); #1; end
      checks++;
      if (oMemReq !== 1'b1 || oReadDataM !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL pre_reset_busy: req=%b rd=%h expected 1 cafef00d", oMemReq, oReadDataM);
      end
      iRstN = 1'b0;
      #1;
      exp_rd = '0;
      checks++;
      if ({oMemReq, oStallM, oBusErrM} !== 3'b000 || oReadDataM !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: req,stall,buserr=%b rd=%h expected 000 00000000",
                  {oMemReq, oStallM, oBusErrM}, oReadDataM);
      end
      @(negedge iClk);
      iMemReadM = 1'b0;
      @(posedge iClk); #1;
      iRstN = 1'b1;
      @(negedge iClk);
      checks++;
      if ({oMemReq, oStallM} !== 2'b00) begin
         errors++;
         $display("FAIL post_reset_idle: req,stall=%b expected 00", {oMemReq, oStallM});
      end
      run_access(1'b1, 1'b0, 3'b001, 32'h302, 32'h0, 2, 32'h8001_7FFF);
   endtask

   task automatic test_back_to_back();
      run_access(1'b1, 1'b1, 3'b000, 32'h503, 32'h0000_00C3, 1, 32'h0);
      run_access(1'b1, 1'b0, 3'b101, 32'h502, 32'h0, 1, 32'h9ABC_0000);
      run_access(1'b1, 1'b0, 3'b001, 32'h500, 32'h0, 1, 32'h0000_8123);
   endtask

   task automatic test_random();
      for (int i = 0; i < 48; i++) begin
         bit          rd;
         bit          wr;
         logic [2:0]  f3;
         logic [31:0] addr;
         int          ack;
         wr = ($urandom_range(0, 2) == 0);
         rd = wr ? 1'($urandom) : 1'b1;
         if (wr) f3 = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'b011;
         else    f3 = 3'($urandom_range(0, 7));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nbytes(f3) - 1);
         ack = $urandom_range(0, TO);
         run_access(rd, wr, f3, addr, $urandom, ack, $urandom);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its summary in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_load_word();
      test_load_byte();
      test_store_half();
      test_misalign();
      test_idle_hold();
      test_timeout();
      test_reset_mid_busy();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
